// File: rtl/multi_word_transmitter_pkg.sv
// Shared widths, FSM state type and helpers for the multi-word byte transmitter.
package tx_pkg;

   localparam int unsigned DEF_WORD_BYTES = 4;
   localparam int unsigned DEF_BYTE_W     = 8;
   localparam int unsigned DEF_DEPTH      = 4;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } tx_state_t;

   // Ceiling log2; clog2(1) = 0.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < value) begin
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/multi_word_transmitter_fifo.sv
// Synchronous word FIFO with extra-MSB pointers for full/empty disambiguation.
// A write against a full FIFO is accepted when a read happens in the same cycle.
module sync_fifo
   import tx_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_rd   = rd_en && !empty;
   assign do_wr   = wr_en && (!full || do_rd);
   assign rd_data = mem[rd_ptr[AW-1:0]];

   // Storage array; contents need no reset since pointers gate visibility.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr[AW-1:0]] <= wr_data;
      end
   end

   // Pointer update, wrapping modulo 2*DEPTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

endmodule

// File: rtl/multi_word_transmitter.sv
// Buffers result words in a FIFO and emits them one byte per rising edge of
// data_request, in selectable byte order, with overflow and dropped-request flags.
module multi_word_transmitter
   import tx_pkg::*;
#(
   parameter int unsigned WORD_BYTES = DEF_WORD_BYTES,
   parameter int unsigned BYTE_W     = DEF_BYTE_W,
   parameter int unsigned DEPTH      = DEF_DEPTH,
   parameter bit          MSB_FIRST  = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [WORD_BYTES*BYTE_W-1:0] in_data,
   input  logic                         in_data_ready,
   input  logic                         data_request,
   output logic [BYTE_W-1:0]            out_data,
   output logic                         out_data_ready,
   output logic                         fifo_full,
   output logic                         fifo_empty,
   output logic                         busy,
   output logic                         overflow,
   output logic                         req_dropped
);

   localparam int unsigned W  = WORD_BYTES * BYTE_W;
   localparam int unsigned CW = (clog2(WORD_BYTES) > 0) ? clog2(WORD_BYTES) : 1;

   tx_state_t       state;
   logic [W-1:0]    shreg;
   logic [CW-1:0]   byte_cnt;
   logic            data_request_q;
   logic            req_edge;
   logic            pop;
   logic            last_byte;
   logic [W-1:0]    fifo_rd_data;
   logic [W-1:0]    shifted;
   logic [BYTE_W-1:0] sel_byte;

   assign req_edge  = data_request && !data_request_q;
   assign pop       = (state == IDLE) && !fifo_empty;
   assign last_byte = (byte_cnt == CW'(WORD_BYTES - 1));

   sync_fifo #(
      .WIDTH (W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (in_data_ready),
      .wr_data (in_data),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Pick the byte addressed by byte_cnt in the configured byte order.
   always_comb begin
      int unsigned idx;
      idx = 32'(byte_cnt);
      if (MSB_FIRST) begin
         idx = WORD_BYTES - 1 - 32'(byte_cnt);
      end
      shifted  = shreg >> (idx * BYTE_W);
      sel_byte = shifted[BYTE_W-1:0];
   end

   // Request edge register, overflow flag and IDLE/ACTIVE byte-emission FSM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         shreg          <= '0;
         byte_cnt       <= '0;
         data_request_q <= 1'b0;
         out_data       <= '0;
         out_data_ready <= 1'b0;
         busy           <= 1'b0;
         overflow       <= 1'b0;
         req_dropped    <= 1'b0;
      end else begin
         data_request_q <= data_request;
         out_data_ready <= 1'b0;
         req_dropped    <= 1'b0;
         // A write on a full FIFO survives only if the head is popped this cycle.
         if (in_data_ready && fifo_full && !pop) begin
            overflow <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (req_edge) begin
                  req_dropped <= 1'b1;
               end
               if (!fifo_empty) begin
                  shreg    <= fifo_rd_data;
                  byte_cnt <= '0;
                  busy     <= 1'b1;
                  state    <= ACTIVE;
               end
            end
            ACTIVE: begin
               if (req_edge) begin
                  out_data       <= sel_byte;
                  out_data_ready <= 1'b1;
                  if (last_byte) begin
                     byte_cnt <= '0;
                     busy     <= 1'b0;
                     state    <= IDLE;
                  end else begin
                     byte_cnt <= byte_cnt + CW'(1);
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multi_word_transmitter.sv
// Directed bench: one MSB-first and one LSB-first transmitter driven in parallel.
module tb_multi_word_transmitter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] in_data = '0;
   logic        in_data_ready = 1'b0;
   logic        data_request = 1'b0;

   logic [7:0]  out_data, out_data_l;
   logic        out_data_ready, out_data_ready_l;
   logic        fifo_full, fifo_full_l;
   logic        fifo_empty, fifo_empty_l;
   logic        busy, busy_l;
   logic        overflow, overflow_l;
   logic        req_dropped, req_dropped_l;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   multi_word_transmitter #(
      .WORD_BYTES (4), .BYTE_W (8), .DEPTH (4), .MSB_FIRST (1'b1)
   ) dut_msb (
      .clk (clk), .rst (rst), .in_data (in_data), .in_data_ready (in_data_ready),
      .data_request (data_request), .out_data (out_data),
      .out_data_ready (out_data_ready), .fifo_full (fifo_full),
      .fifo_empty (fifo_empty), .busy (busy), .overflow (overflow),
      .req_dropped (req_dropped)
   );

   multi_word_transmitter #(
      .WORD_BYTES (4), .BYTE_W (8), .DEPTH (4), .MSB_FIRST (1'b0)
   ) dut_lsb (
      .clk (clk), .rst (rst), .in_data (in_data), .in_data_ready (in_data_ready),
      .data_request (data_request), .out_data (out_data_l),
      .out_data_ready (out_data_ready_l), .fifo_full (fifo_full_l),
      .fifo_empty (fifo_empty_l), .busy (busy_l), .overflow (overflow_l),
      .req_dropped (req_dropped_l)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [31:0] w);
      in_data       = w;
      in_data_ready = 1'b1;
      tick();
      in_data_ready = 1'b0;
   endtask

   // One request pulse: byte appears right after the sampling edge, then the pulse clears.
   task automatic send_req(input string tag, input logic [7:0] exp_msb);
      data_request = 1'b1;
      tick();
      data_request = 1'b0;
      check({tag, "_rdy"}, 32'(out_data_ready), 32'd1);
      check({tag, "_data"}, 32'(out_data), 32'(exp_msb));
      tick();
      check({tag, "_rdy_clr"}, 32'(out_data_ready), 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   logic [31:0] words [6];
   logic [7:0]  lsb_exp [4];

   initial begin
      words[0] = 32'h11223344;
      words[1] = 32'h55667788;
      words[2] = 32'h99AABBCC;
      words[3] = 32'hDDEEFF01;
      words[4] = 32'h02030405;
      words[5] = 32'hDEADBEEF;
      lsb_exp[0] = 8'h56; lsb_exp[1] = 8'hC6; lsb_exp[2] = 8'h9B; lsb_exp[3] = 8'h00;

      // Reset values
      do_reset();
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_ready", 32'(out_data_ready), 32'd0);
      check("rst_full", 32'(fifo_full), 32'd0);
      check("rst_empty", 32'(fifo_empty), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      check("rst_drop", 32'(req_dropped), 32'd0);

      // Request with empty FIFO is dropped
      data_request = 1'b1;
      tick();
      data_request = 1'b0;
      check("drop_pulse", 32'(req_dropped), 32'd1);
      check("drop_no_rdy", 32'(out_data_ready), 32'd0);
      check("drop_data", 32'(out_data), 32'd0);
      tick();
      check("drop_clr", 32'(req_dropped), 32'd0);

      // Single word, both byte orders
      write_word(32'h009BC656);
      check("w1_empty", 32'(fifo_empty), 32'd0);
      check("w1_busy_pre", 32'(busy), 32'd0);
      tick();
      check("w1_busy", 32'(busy), 32'd1);
      check("w1_empty_pop", 32'(fifo_empty), 32'd1);
      for (int i = 0; i < 4; i++) begin
         data_request = 1'b1;
         tick();
         data_request = 1'b0;
         check($sformatf("msb_rdy%0d", i), 32'(out_data_ready), 32'd1);
         check($sformatf("lsb_rdy%0d", i), 32'(out_data_ready_l), 32'd1);
         check($sformatf("lsb_byte%0d", i), 32'(out_data_l), 32'(lsb_exp[i]));
         case (i)
            0: check("msb_byte0", 32'(out_data), 32'h00);
            1: check("msb_byte1", 32'(out_data), 32'h9B);
            2: check("msb_byte2", 32'(out_data), 32'hC6);
            default: check("msb_byte3", 32'(out_data), 32'h56);
         endcase
         tick();
         check($sformatf("hold_byte%0d", i), 32'(out_data_ready), 32'd0);
      end
      check("w1_busy_done", 32'(busy), 32'd0);
      check("w1_empty_done", 32'(fifo_empty), 32'd1);
      check("w1_hold_data", 32'(out_data), 32'h56);

      // Held request: high 2 cycles, low 3, high 1 -> two bytes
      write_word(32'hA1B2C3D4);
      tick();
      data_request = 1'b1;
      tick();
      check("held_rdy0", 32'(out_data_ready), 32'd1);
      check("held_byte0", 32'(out_data), 32'hA1);
      tick();
      data_request = 1'b0;
      check("held_no_second", 32'(out_data_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("held_low%0d", i), 32'(out_data_ready), 32'd0);
      end
      check("held_data_kept", 32'(out_data), 32'hA1);
      data_request = 1'b1;
      tick();
      data_request = 1'b0;
      check("held_rdy1", 32'(out_data_ready), 32'd1);
      check("held_byte1", 32'(out_data), 32'hB2);
      tick();
      send_req("held_b2", 8'hC3);
      send_req("held_b3", 8'hD4);
      check("held_idle", 32'(busy), 32'd0);

      // Overflow: word 1 moves into the shift register, words 2-5 fill the FIFO, word 6 drops
      do_reset();
      in_data_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_data = words[i];
         tick();
         if (i == 4) begin
            check("ovf_full", 32'(fifo_full), 32'd1);
            check("ovf_not_yet", 32'(overflow), 32'd0);
         end
      end
      in_data_ready = 1'b0;
      check("ovf_set", 32'(overflow), 32'd1);
      check("ovf_full2", 32'(fifo_full), 32'd1);
      for (int w = 0; w < 5; w++) begin
         for (int b = 0; b < 4; b++) begin
            send_req($sformatf("drain_w%0d_b%0d", w, b), 8'(words[w] >> (8 * (3 - b))));
         end
      end
      check("drain_empty", 32'(fifo_empty), 32'd1);
      check("drain_busy", 32'(busy), 32'd0);
      check("ovf_sticky", 32'(overflow), 32'd1);

      // Reset mid-word
      do_reset();
      write_word(32'h009BC656);
      write_word(32'h12345678);
      send_req("mid_b0", 8'h00);
      send_req("mid_b1", 8'h9B);
      check("mid_busy_pre", 32'(busy), 32'd1);
      check("mid_empty_pre", 32'(fifo_empty), 32'd0);
      rst = 1'b1;
      #1;
      check("mid_rst_data", 32'(out_data), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_empty", 32'(fifo_empty), 32'd1);
      check("mid_rst_full", 32'(fifo_full), 32'd0);
      #3;
      rst = 1'b0;
      tick();
      data_request = 1'b1;
      tick();
      data_request = 1'b0;
      check("mid_after_drop", 32'(req_dropped), 32'd1);
      check("mid_after_rdy", 32'(out_data_ready), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
